// File: rtl/r_type_ctrl_if.sv
// r_type_ctrl_if: instruction handshake and datapath control bundle for r_type_ctrl
interface r_type_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        hold;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [4:0]  W_Addr;
  logic [3:0]  ALU_OP;
  logic        Reg_Write;
  logic        rr_pulse;
  logic        f_pulse;
  logic        wb_pulse;
  logic        illegal;
  logic [31:0] retired_cnt;
  modport master (
    output instr, instr_valid, hold,
    input  instr_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
           rr_pulse, f_pulse, wb_pulse, illegal, retired_cnt
  );
  modport slave (
    input  instr, instr_valid, hold,
    output instr_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
           rr_pulse, f_pulse, wb_pulse, illegal, retired_cnt
  );
endinterface

// File: rtl/r_type_ctrl.sv
// r_type_ctrl: multi-cycle RV32I R-type sequencer stepping the datapath through RR, EX and WB
module r_type_ctrl (
  input logic          clk,
  input logic          rst,
  r_type_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RR, EX, WB, ILL} state_t;
  state_t      state_q;
  logic [31:0] ir_q;
  logic [31:0] cnt_q;
  logic        legal;
  always_comb
    legal = bus.instr[6:0] == 7'b0110011 &&
            (bus.instr[31:25] == 7'b0000000 ||
             (bus.instr[31:25] == 7'b0100000 &&
              (bus.instr[14:12] == 3'b000 || bus.instr[14:12] == 3'b101)));
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.instr_valid) begin
          ir_q    <= bus.instr;
          state_q <= legal ? RR : ILL;
        end
        RR: state_q <= bus.hold ? RR : EX;
        EX: state_q <= bus.hold ? EX : WB;
        WB: if (!bus.hold) begin
          state_q <= IDLE;
          cnt_q   <= cnt_q + 32'd1;
        end
        ILL: begin
          state_q <= IDLE;
          cnt_q   <= cnt_q + 32'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  // Strobes come straight off the state flop; hold only masks them, so each fires once per phase.
  assign bus.instr_ready = state_q == IDLE;
  assign bus.rr_pulse    = state_q == RR && !bus.hold;
  assign bus.f_pulse     = state_q == EX && !bus.hold;
  assign bus.wb_pulse    = state_q == WB && !bus.hold;
  assign bus.illegal     = state_q == ILL;
  assign bus.Reg_Write   = state_q == WB && ir_q[11:7] != 5'd0;
  assign bus.R_Addr_A    = ir_q[19:15];
  assign bus.R_Addr_B    = ir_q[24:20];
  assign bus.W_Addr      = ir_q[11:7];
  assign bus.ALU_OP      = {ir_q[30], ir_q[14:12]};
  assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_r_type_ctrl.sv
// tb_r_type_ctrl: scoreboard bench; stimulus queues expected strobes, a negedge monitor pops and compares them
module tb_r_type_ctrl;
  logic clk = 0;
  logic rst = 1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_cnt = 0;
  typedef struct {
    int         kind;
    int         at;
    logic [4:0] a, b, w;
    logic [3:0] op;
    logic       rw;
  } exp_t;
  exp_t q[$];
  r_type_ctrl_if bus ();
  r_type_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push(input int kind, input int at, input logic [4:0] a, b, w,
                      input logic [3:0] op, input logic rw);
    exp_t e;
    e.kind = kind; e.at = at; e.a = a; e.b = b; e.w = w; e.op = op; e.rw = rw;
    q.push_back(e);
  endtask
  // Monitor: every strobe must match the head of the scoreboard in kind and cycle.
  always @(negedge clk) begin
    int   kind;
    exp_t e;
    if (bus.Reg_Write) chk("rw_only_in_wb", 32'(bus.wb_pulse | bus.hold), 1);
    if (bus.rr_pulse | bus.f_pulse | bus.wb_pulse | bus.illegal) begin
      kind = bus.rr_pulse ? 0 : bus.f_pulse ? 1 : bus.wb_pulse ? 2 : 3;
      chk("strobe_onehot", $countones({bus.rr_pulse, bus.f_pulse, bus.wb_pulse, bus.illegal}), 1);
      chk("strobe_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("strobe_cycle", cyc, e.at);
        if (kind == 0) begin
          chk("rr_addr_a", bus.R_Addr_A, e.a);
          chk("rr_addr_b", bus.R_Addr_B, e.b);
          chk("rr_waddr", bus.W_Addr, e.w);
          chk("rr_alu_op", bus.ALU_OP, e.op);
        end
        if (kind == 2) chk("wb_reg_write", bus.Reg_Write, e.rw);
        if (kind != 2) chk("reg_write_low", bus.Reg_Write, 0);
      end
    end
  end
  task automatic send(input logic [31:0] ins, input bit legal, input logic [4:0] a, b, w,
                      input logic [3:0] op, input int h, input bit keep);
    int n, t, rdy;
    t = 0;
    while (!bus.instr_ready && t < 20) begin @(posedge clk); #1; t++; end
    chk("ready_wait", bus.instr_ready, 1);
    n = cyc;
    bus.instr = ins;
    bus.instr_valid = 1;
    if (legal) begin
      push(0, n + 1, a, b, w, op, 0);
      push(1, n + 2 + h, 0, 0, 0, 0, 0);
      push(2, n + 3 + h, 0, 0, 0, 0, w != 0);
    end else push(3, n + 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    if (!keep) bus.instr_valid = 0;
    if (legal && h > 0) begin
      @(posedge clk); #1;
      bus.hold = 1;
      repeat (h) begin @(posedge clk); #1; end
      bus.hold = 0;
    end
    rdy = legal ? n + 4 + h : n + 2;
    while (cyc < rdy - 1) begin @(posedge clk); #1; end
    chk("busy_not_ready", bus.instr_ready, 0);
    chk("cnt_before_retire", bus.retired_cnt, exp_cnt);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1;
    chk("ready_on_time", bus.instr_ready, 1);
    chk("retired_cnt", bus.retired_cnt, exp_cnt);
    if (legal) chk("addr_a_stable", bus.R_Addr_A, a);
  endtask
  initial begin
    int n;
    bus.instr = 0; bus.instr_valid = 0; bus.hold = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_addr_a", bus.R_Addr_A, 0);
    chk("rst_addr_b", bus.R_Addr_B, 0);
    chk("rst_waddr", bus.W_Addr, 0);
    chk("rst_alu_op", bus.ALU_OP, 0);
    chk("rst_pulses", {bus.rr_pulse, bus.f_pulse, bus.wb_pulse, bus.illegal, bus.Reg_Write}, 0);
    chk("rst_cnt", bus.retired_cnt, 0);
    // Reset while in EX: rr and f fire, then abort with no write-back and no count.
    n = cyc;
    bus.instr = 32'h0020B1B3; bus.instr_valid = 1;
    push(0, n + 1, 5'd1, 5'd2, 5'd3, 4'b0011, 0);
    push(1, n + 2, 0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.instr_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("abort_ready", bus.instr_ready, 1);
    chk("abort_cnt", bus.retired_cnt, 0);
    chk("abort_ir_a", bus.R_Addr_A, 0);
    chk("abort_ir_w", bus.W_Addr, 0);
    chk("abort_ir_op", bus.ALU_OP, 0);
    repeat (3) @(posedge clk); #1;
    send(32'h002081B3, 1, 5'd1, 5'd2, 5'd3, 4'b0000, 0, 0);
    send(32'h407302B3, 1, 5'd6, 5'd7, 5'd5, 4'b1000, 0, 1);
    send(32'h0020C233, 1, 5'd1, 5'd2, 5'd4, 4'b0100, 0, 0);
    send(32'h00000013, 0, 0, 0, 0, 0, 0, 0);
    send(32'h4020C033, 0, 0, 0, 0, 0, 0, 0);
    send(32'h00208033, 1, 5'd1, 5'd2, 5'd0, 4'b0000, 0, 0);
    send(32'h4020D1B3, 1, 5'd1, 5'd2, 5'd3, 4'b1101, 3, 0);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1 release dut.cnt_q;
    exp_cnt = 32'hFFFFFFFF;
    send(32'h00000013, 0, 0, 0, 0, 0, 0, 0);
    send(32'h0020B1B3, 1, 5'd1, 5'd2, 5'd3, 4'b0011, 0, 0);
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
